// File: rtl/sum_pipe_pkg.sv
// Shared defaults and the segment-count helper for the segmented pipelined adder.
`default_nettype none

package sum_pipe_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int SEG_W_DEF = 2;
  localparam int IDX_W_DEF = 4;

  // Returns 0 for an illegal split so callers can reject it at elaboration.
  function automatic int nseg(input int width, input int seg_w);
    if (seg_w <= 0 || width <= 0 || (width % seg_w) != 0) return 0;
    return width / seg_w;
  endfunction

  localparam int NSEG_DEF = nseg(WIDTH_DEF, SEG_W_DEF);
  localparam bit DEF_CFG_OK = (NSEG_DEF >= 1);

endpackage

`default_nettype wire

// File: rtl/sum_seg_stage.sv
// One pipeline stage: adds segment K of the skewed operands plus the registered carry.
`default_nettype none

module sum_seg_stage
  import sum_pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEG_W = SEG_W_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             adv,
  input  logic             prev_valid,
  input  logic [IDX_W-1:0] prev_idx,
  input  logic [WIDTH-1:0] prev_a,
  input  logic [WIDTH-1:0] prev_b,
  input  logic [WIDTH-1:0] prev_sum,
  input  logic             prev_carry,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int LO = K * SEG_W;

  logic [SEG_W:0]   seg_sum;
  logic [WIDTH-1:0] next_sum;

  always_comb begin
    seg_sum  = {1'b0, prev_a[LO +: SEG_W]} + {1'b0, prev_b[LO +: SEG_W]}
             + {{SEG_W{1'b0}}, prev_carry};
    next_sum = prev_sum;
    next_sum[LO +: SEG_W] = seg_sum[SEG_W-1:0];
  end

  // Every flop, including valid, moves only when the whole pipe advances.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      valid <= 1'b0;
      idx   <= '0;
      a     <= '0;
      b     <= '0;
      sum   <= '0;
      carry <= 1'b0;
    end else if (adv) begin
      valid <= prev_valid;
      idx   <= prev_idx;
      a     <= prev_a;
      b     <= prev_b;
      sum   <= next_sum;
      carry <= seg_sum[SEG_W];
    end
  end

endmodule

`default_nettype wire

// File: rtl/sum_pipe_seg.sv
// Segmented pipelined adder with tag and ready/valid; SUM_PIPE_OVF_EN adds the carry_out port.
`default_nettype none

module sum_pipe_seg
  import sum_pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEG_W = SEG_W_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] idx,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] idx_out,
  output logic [WIDTH-1:0] sum_out
`ifdef SUM_PIPE_OVF_EN
  ,
  output logic             carry_out
`endif
);

  localparam int NSEG = nseg(WIDTH, SEG_W);

  if (NSEG < 1) begin : g_cfg_err
    $error("sum_pipe_seg: WIDTH must be a positive multiple of SEG_W");
  end

  logic             adv;
  logic [NSEG:0]    v_ch;
  logic [NSEG:0]    c_ch;
  logic [IDX_W-1:0] idx_ch [NSEG+1];
  logic [WIDTH-1:0] a_ch   [NSEG+1];
  logic [WIDTH-1:0] b_ch   [NSEG+1];
  logic [WIDTH-1:0] sum_ch [NSEG+1];

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  assign v_ch[0]   = in_valid;
  assign c_ch[0]   = 1'b0;
  assign idx_ch[0] = idx;
  assign a_ch[0]   = dataA;
  assign b_ch[0]   = dataB;
  assign sum_ch[0] = '0;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    sum_seg_stage #(
      .WIDTH (WIDTH),
      .SEG_W (SEG_W),
      .IDX_W (IDX_W),
      .K     (k)
    ) u_stage (
      .clk        (clk),
      .reset_L    (reset_L),
      .adv        (adv),
      .prev_valid (v_ch[k]),
      .prev_idx   (idx_ch[k]),
      .prev_a     (a_ch[k]),
      .prev_b     (b_ch[k]),
      .prev_sum   (sum_ch[k]),
      .prev_carry (c_ch[k]),
      .valid      (v_ch[k+1]),
      .idx        (idx_ch[k+1]),
      .a          (a_ch[k+1]),
      .b          (b_ch[k+1]),
      .sum        (sum_ch[k+1]),
      .carry      (c_ch[k+1])
    );
  end

  assign out_valid = v_ch[NSEG];
  assign idx_out   = idx_ch[NSEG];
  assign sum_out   = sum_ch[NSEG];

  // Operands leaving the last stage have no consumer.
  logic unused_tail;
`ifdef SUM_PIPE_OVF_EN
  assign carry_out   = c_ch[NSEG];
  assign unused_tail = ^{a_ch[NSEG], b_ch[NSEG]};
`else
  assign unused_tail = ^{a_ch[NSEG], b_ch[NSEG], c_ch[NSEG]};
`endif

endmodule

`default_nettype wire
